bus_arbiter32: RTL and testbench

Round-robin arbiter and sequencer for the shared 32-bit CPU bus. Up to 32 bus sources (registers, PC, MDR, ALU result, etc.) raise a drive request. The block grants exactly one source at a time, holds that grant for a bounded number of cycles, and inserts a one-cycle turnaround between owners. It outputs both the one-hot grant vector and the registered 5-bit binary select used by the bus multiplexer, replacing a free-running combinational encode of the "out" strobes.

---
 rtl/bus_arbiter32.sv | 85 ++++++++
 tb/tb_bus_arbiter32.sv | 130 +++++++++++++
 2 files changed

// File: rtl/bus_arbiter32.sv
// bus_arbiter32: round-robin bus arbiter with bounded hold, one-cycle turnaround and registered mux select
module bus_arbiter32 #(
    parameter int MAX_HOLD = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] req,
    input  logic        enable,
    output logic [31:0] grant,
    output logic [4:0]  code,
    output logic        bus_valid
);
    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
    state_t      fsm_q, fsm_d;
    logic [31:0] grant_q, grant_d;
    logic [4:0]  code_q, code_d, ptr_q, ptr_d, win, idx;
    logic [3:0]  hold_q, hold_d;
    logic        valid_q, valid_d, others;
    always_comb begin
        win = ptr_q;
        idx = ptr_q;
        for (int i = 31; i >= 0; i--) begin
            idx = ptr_q + 5'(i);
            win = req[idx] ? idx : win;
        end
    end
    // code_q doubles as the owner while in GRANT
    assign others = |(req & ~(32'd1 << code_q));
    always_comb begin
        fsm_d   = fsm_q;
        grant_d = grant_q;
        code_d  = code_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        case (fsm_q)
            GRANT: begin
                if (!req[code_q] || (hold_q == HOLD_MAX && others)) begin
                    fsm_d   = TURN;
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = code_q + 5'd1;
                end else begin
                    hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 4'd1;
                end
            end
            default: begin
                if (enable && |req) begin
                    fsm_d   = GRANT;
                    grant_d = 32'd1 << win;
                    code_d  = win;
                    valid_d = 1'b1;
                    hold_d  = 4'd1;
                end else begin
                    fsm_d   = IDLE;
                    grant_d = '0;
                    code_d  = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                end
            end
        endcase
    end
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            fsm_q   <= IDLE;
            grant_q <= '0;
            code_q  <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            grant_q <= grant_d;
            code_q  <= code_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end
    assign grant     = grant_q;
    assign code      = code_q;
    assign bus_valid = valid_q;
endmodule

// File: tb/tb_bus_arbiter32.sv
// tb_bus_arbiter32: directed vectors for the round-robin bus arbiter
module tb_bus_arbiter32;
    logic        clock, clear, enable;
    logic [31:0] req, grant;
    logic [4:0]  code;
    logic        bus_valid;
    int          n_vec, n_err;
    bus_arbiter32 dut (
        .clock(clock), .clear(clear), .req(req), .enable(enable),
        .grant(grant), .code(code), .bus_valid(bus_valid)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic do_clear();
        req   = '0;
        clear = 1'b1;
        #1;
        clear = 1'b0;
    endtask
    localparam logic [31:0] RR = 32'h8000_0003;
    logic [4:0] rr_seq [4] = '{5'd0, 5'd1, 5'd31, 5'd0};
    initial begin
        n_vec = 0; n_err = 0;
        clock = 0; clear = 0; req = '0; enable = 1'b1;
        #1 clear = 1'b1;
        #1;
        check("rst_grant", grant, 32'h0);
        check("rst_code", {27'd0, code}, 32'd0);
        check("rst_valid", {31'd0, bus_valid}, 32'd0);
        clear = 1'b0;
        step(1);
        // single request and release
        req = 32'h10;
        step(1);
        check("single_grant", grant, 32'h10);
        check("single_code", {27'd0, code}, 32'd4);
        check("single_valid", {31'd0, bus_valid}, 32'd1);
        req = '0;
        step(1);
        check("release_grant", grant, 32'h0);
        check("release_valid", {31'd0, bus_valid}, 32'd0);
        step(1);
        check("idle_code", {27'd0, code}, 32'd0);
        // round robin with wrap through source 31
        do_clear();
        req = RR;
        foreach (rr_seq[k]) begin
            step(1);
            check("rr_grant", grant, 32'd1 << rr_seq[k]);
            check("rr_code", {27'd0, code}, {27'd0, rr_seq[k]});
            req = RR & ~(32'd1 << rr_seq[k]);
            step(1);
            check("rr_turn", {31'd0, bus_valid}, 32'd0);
            req = RR;
        end
        // forced release after MAX_HOLD cycles
        step(1);
        do_clear();
        req = 32'h20;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("hold_grant", grant, 32'h20);
            if (i == 1) req = 32'h220;
        end
        step(1);
        check("forced_turn", grant, 32'h0);
        step(1);
        check("forced_next", {27'd0, code}, 32'd9);
        check("forced_next_grant", grant, 32'h200);
        // sole holder keeps the bus indefinitely
        step(1);
        do_clear();
        req = 32'h100;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("sole_grant", grant, 32'h100);
        end
        req = 32'h101;
        step(1);
        check("sole_release", grant, 32'h0);
        step(1);
        check("sole_next", {27'd0, code}, 32'd0);
        check("sole_next_grant", grant, 32'h1);
        // enable gating, ptr is now 1 after releasing owner 0
        req = '0;
        enable = 1'b0;
        step(1);
        req = 32'hFFFF_FFFF;
        step(1);
        check("gated_grant", grant, 32'h0);
        step(2);
        check("gated_valid", {31'd0, bus_valid}, 32'd0);
        enable = 1'b1;
        step(1);
        check("enable_code", {27'd0, code}, 32'd1);
        enable = 1'b0;
        step(1);
        check("enable_drop_hold", grant, 32'h2);
        step(1);
        check("enable_drop_hold2", grant, 32'h2);
        // asynchronous clear mid-grant
        enable = 1'b1;
        do_clear();
        req = 32'h0002_0000;
        step(1);
        check("pre_clear_code", {27'd0, code}, 32'd17);
        #2 clear = 1'b1;
        #1;
        check("async_grant", grant, 32'h0);
        check("async_valid", {31'd0, bus_valid}, 32'd0);
        check("async_code", {27'd0, code}, 32'd0);
        req = 32'h0002_0001;
        clear = 1'b0;
        step(1);
        check("post_clear_code", {27'd0, code}, 32'd0);
        check("post_clear_grant", grant, 32'h1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
